// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor front-end blocks.
// Scheduler FSM encoding and default bit-clock divider sizing live here.
package sensor_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_RUN,
    SCHED_DONE
  } sched_state_t;

  localparam int CLK_PER_BIT_DEFAULT = 5;
  localparam int CNT_W               = 8;

endpackage

// File: rtl/bitclk_divider.sv
// Divides clk into a 50% duty bit clock while en is high; held low and cleared otherwise.
// rise/fall are combinational look-aheads: high in the cycle before out_clk toggles.
module bitclk_divider
  import sensor_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic out_clk,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(CLK_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

  logic [CW-1:0] count;
  logic          wrap;

  assign wrap = en && (count == LAST);
  assign rise = wrap && !out_clk;
  assign fall = wrap && out_clk;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      count   <= '0;
      out_clk <= 1'b0;
    end else if (wrap) begin
      count   <= '0;
      out_clk <= ~out_clk;
    end else begin
      count   <= count + 1'b1;
    end
  end

endmodule

// File: rtl/bitclk_scheduler.sv
// Round-robin owner of the shared serial bit clock: grants one requester at a time
// and runs the divider for exactly that requester's nbits periods.
module bitclk_scheduler
  import sensor_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT,
  parameter int CNT_W       = sensor_pkg::CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] nbits,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic                   out_clk,
  output logic                   bit_strobe,
  output logic [N_REQ-1:0]       done
);

  localparam int IDX_W = $clog2(N_REQ);

  sched_state_t     state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] pick_idx;
  logic             bit_strobe_q;
  logic             div_en, div_rise, div_fall;
  logic             zero_burst;

  // First requester after 'last', wrapping around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = last;
    found = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(last) + off) % N_REQ;
      if (!found && r[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign pick_idx = rr_pick(req, last_q);

  // In RUN, remain==0 with out_clk low only happens for a zero-length grant:
  // after the last rise out_clk stays high until the fall that leaves RUN.
  assign zero_burst = (remain_q == '0) && !out_clk;
  assign div_en     = (state_q == SCHED_RUN) && !zero_burst;

  bitclk_divider #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .en     (div_en),
    .out_clk(out_clk),
    .rise   (div_rise),
    .fall   (div_fall)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    remain_d = remain_q;
    last_d   = last_q;
    unique case (state_q)
      SCHED_IDLE: begin
        if (|req) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          remain_d          = nbits[pick_idx*CNT_W +: CNT_W];
          last_d            = pick_idx;
          state_d           = SCHED_RUN;
        end
      end
      SCHED_RUN: begin
        if (div_rise && (remain_q != '0)) remain_d = remain_q - 1'b1;
        if (zero_burst || (div_fall && (remain_q == '0))) begin
          done_d  = grant_q;
          grant_d = '0;
          state_d = SCHED_DONE;
        end
      end
      SCHED_DONE: state_d = SCHED_IDLE;
      default:    state_d = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    if (rst) begin
      state_q      <= SCHED_IDLE;
      grant_q      <= '0;
      done_q       <= '0;
      remain_q     <= '0;
      last_q       <= IDX_W'(N_REQ - 1);
      bit_strobe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      remain_q     <= remain_d;
      last_q       <= last_d;
      bit_strobe_q <= div_rise;
    end
  end

  assign grant      = grant_q;
  assign busy       = |grant_q;
  assign done       = done_q;
  assign bit_strobe = bit_strobe_q;

endmodule

// File: tb/tb_bitclk_scheduler.sv
// Directed bench for bitclk_scheduler with N_REQ=2, CLK_PER_BIT=5, CNT_W=8.
// Inputs change and outputs are sampled on the falling edge; cyc counts rising edges.
module tb_bitclk_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [15:0] nbits = '0;
  logic [1:0]  grant;
  logic        busy;
  logic        out_clk;
  logic        bit_strobe;
  logic [1:0]  done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int   rise_q[$];
  int   strobe_n     = 0;
  int   strobe_err   = 0;
  int   both_granted = 0;
  int   done_n       = 0;
  logic prev_clk     = 1'b0;

  bitclk_scheduler #(
    .N_REQ      (2),
    .CLK_PER_BIT(5),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .nbits     (nbits),
    .grant     (grant),
    .busy      (busy),
    .out_clk   (out_clk),
    .bit_strobe(bit_strobe),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_clk && !prev_clk) rise_q.push_back(cyc);
    if (bit_strobe !== (out_clk && !prev_clk)) strobe_err++;
    if (bit_strobe) strobe_n++;
    if (grant == 2'b11) both_granted++;
    if (done != 2'b00) done_n++;
    prev_clk = out_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rise_q.delete();
    strobe_n = 0;
    done_n   = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_out_clk", out_clk, 0);
    check("rst_strobe", bit_strobe, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    clear_logs();
  endtask

  // Waits for a non-zero grant; a timeout leaves g=-1 and fails the cycle check.
  task automatic wait_grant(input string tag, input int exp_cyc, input logic [1:0] exp_grant,
                            output int g);
    g = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (grant != 2'b00) begin
        g = cyc;
        break;
      end
    end
    check({tag, "_cyc"}, g, exp_cyc);
    check({tag, "_val"}, grant, exp_grant);
    check({tag, "_busy"}, busy, 1);
  endtask

  task automatic wait_done(input string tag, input int exp_cyc, input logic [1:0] exp_done);
    int d;
    logic [1:0] v;
    d = -1;
    v = '0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        d = cyc;
        v = done;
        break;
      end
    end
    check({tag, "_cyc"}, d, exp_cyc);
    check({tag, "_val"}, v, exp_done);
    check({tag, "_grant0"}, grant, 0);
    check({tag, "_clk_low"}, out_clk, 0);
  endtask

  task automatic check_rises(input string tag, input int g, input int n);
    check({tag, "_rise_cnt"}, rise_q.size(), n);
    check({tag, "_strobe_cnt"}, strobe_n, n);
    for (int i = 0; i < n; i++)
      check({tag, "_rise_at"}, (i < rise_q.size()) ? rise_q[i] : -1, g + 5 + 10 * i);
  endtask

  initial begin
    int g, g1, c;

    // Single burst: 3 bits from requester 0.
    do_reset();
    nbits = {8'd0, 8'd3};
    req   = 2'b01;
    c     = cyc;
    wait_grant("single_grant", c + 1, 2'b01, g);
    wait_done("single_done", g + 30, 2'b01);
    req = 2'b00;
    check_rises("single", g, 3);

    // Simultaneous requests straight after reset: requester 0 first.
    do_reset();
    nbits = {8'd2, 8'd1};
    req   = 2'b11;
    c     = cyc;
    wait_grant("simul_g0", c + 1, 2'b01, g);
    wait_done("simul_d0", g + 10, 2'b01);
    req = 2'b10;
    wait_grant("simul_g1", g + 12, 2'b10, g1);
    wait_done("simul_d1", g1 + 20, 2'b10);
    req = 2'b00;

    // Fairness: both held, done alternates.
    do_reset();
    nbits = {8'd1, 8'd1};
    req   = 2'b11;
    c     = cyc;
    for (int k = 0; k < 4; k++)
      wait_done("rr_done", c + 11 + 12 * k, (k % 2 == 0) ? 2'b01 : 2'b10);
    req = 2'b00;

    // Zero-length burst on requester 1.
    repeat (3) @(negedge clk);
    clear_logs();
    nbits = {8'd0, 8'd5};
    req   = 2'b10;
    c     = cyc;
    wait_grant("zero_grant", c + 1, 2'b10, g);
    @(negedge clk);
    check("zero_done", done, 2'b10);
    check("zero_grant_off", grant, 0);
    req = 2'b00;
    repeat (15) @(negedge clk);
    check("zero_no_rise", rise_q.size(), 0);
    check("zero_no_strobe", strobe_n, 0);

    // Reset in the middle of a 4-bit burst.
    do_reset();
    nbits = {8'd1, 8'd4};
    req   = 2'b01;
    c     = cyc;
    wait_grant("mid_grant", c + 1, 2'b01, g);
    repeat (12) @(negedge clk);
    check("mid_one_rise", rise_q.size(), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_out_clk", out_clk, 0);
    check("mid_grant0", grant, 0);
    check("mid_busy", busy, 0);
    check("mid_strobe", bit_strobe, 0);
    nbits = {8'd1, 8'd1};
    req   = 2'b11;
    @(negedge clk);
    check("mid_no_done", done_n, 0);
    rst = 1'b0;
    c   = cyc;
    wait_grant("mid_regrant", c + 1, 2'b01, g);
    wait_done("mid_redone", g + 10, 2'b01);
    req = 2'b00;

    // Request withdrawn part way through a 2-bit burst.
    repeat (3) @(negedge clk);
    clear_logs();
    nbits = {8'd7, 8'd2};
    req   = 2'b01;
    c     = cyc;
    wait_grant("wd_grant", c + 1, 2'b01, g);
    repeat (7) @(negedge clk);
    req = 2'b00;
    nbits = {8'd7, 8'd9};
    wait_done("wd_done", g + 20, 2'b01);
    check_rises("wd", g, 2);

    check("strobe_coincident", strobe_err, 0);
    check("never_both_granted", both_granted, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
